// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler: strips a 16-bit Fibonacci LFSR keystream from an
// N-bit valid/ready word stream. One output register, keystream advances per accepted word.
module xor_descrambler #(
  parameter int          N            = 4,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [15:0]  seed,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         locked,
  output logic [15:0]  word_count
);

  if (N < 1 || N > 16) begin : g_bad_width
    $error("xor_descrambler: N must be in 1..16");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [15:0]  r_lfsr;
  logic [15:0]  w_lfsr_adv;
  logic         r_out_valid;
  logic [N-1:0] r_out_data;
  logic [15:0]  r_word_count;
  logic         w_accept;

  // One Fibonacci step of x^16+x^14+x^13+x^11+1, applied N times per word.
  function automatic logic [15:0] lfsr_adv_n(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < N; i++) begin
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    end
    return v;
  endfunction

  // Valid/ready: a word moves when valid && ready are both high at a rising edge.
  // in_ready is combinational; a seed_load in the same cycle blocks acceptance.
  assign in_ready   = (r_state == S_RUN) && !seed_load && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_lfsr_adv = lfsr_adv_n(r_lfsr);

  always_comb begin
    w_state_nxt = r_state;
    if (seed_load) begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr       <= SEED_DEFAULT;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_word_count <= 16'd0;
    end else if (seed_load) begin
      // A zero seed would lock the LFSR at zero, so it is replaced.
      r_lfsr       <= (seed == 16'd0) ? SEED_DEFAULT : seed;
      r_out_valid  <= 1'b0;
      r_word_count <= 16'd0;
    end else if (w_accept) begin
      r_out_data   <= in_data ^ r_lfsr[N-1:0];
      r_out_valid  <= 1'b1;
      r_lfsr       <= w_lfsr_adv;
      r_word_count <= r_word_count + 16'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign word_count = r_word_count;
  assign locked     = (r_state == S_RUN);

endmodule
